// File: rtl/tile_config_mem_shadow.sv
// tile_config_mem_shadow: shadowed per-tile config memory with frame-per-cycle commit and readback
//
// Frames are written into a shadow array. A Commit copies the shadow array into the
// active ConfigBits, one frame per clock, so the fabric never sees a half-written frame.
// Optional feature macro: CONFIG_MEM_PARITY_EN enables per-frame even-parity checking.
//
// Ports:
//   CLK, resetn      config clock, synchronous active-low reset
//   FrameData        frame write data
//   FrameStrobe      per-frame write enables (several may be high at once)
//   FrameParity      even-parity bit for FrameData (parity build only)
//   Commit           request to copy shadow into active
//   ParityClr        clears the sticky parity error (parity build only)
//   RbReq, RbFrame   readback request and frame index
//   Busy             copy in progress
//   CommitDone       one-cycle pulse when the copy completes
//   CommitRej        one-cycle pulse when a commit is refused
//   RbValid, RbData  readback valid pulse and data (data holds until the next request)
//   ParityErr        sticky parity error flag
//   ParityErrFrame   index of the first errored frame
//   ConfigBits(_N)   active configuration and its bitwise inverse
module tile_config_mem_shadow #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 66
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic [FrameBitsPerRow-1:0]         FrameData,
    input  logic [MaxFramesPerCol-1:0]         FrameStrobe,
    input  logic                               FrameParity,
    input  logic                               Commit,
    input  logic                               ParityClr,
    input  logic                               RbReq,
    input  logic [$clog2(MaxFramesPerCol)-1:0] RbFrame,
    output logic                               Busy,
    output logic                               CommitDone,
    output logic                               CommitRej,
    output logic                               RbValid,
    output logic [FrameBitsPerRow-1:0]         RbData,
    output logic                               ParityErr,
    output logic [$clog2(MaxFramesPerCol)-1:0] ParityErrFrame,
    output logic [NoConfigBits-1:0]            ConfigBits,
    output logic [NoConfigBits-1:0]            ConfigBits_N
);
    localparam int NumFrames = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int IW        = $clog2(MaxFramesPerCol);
    localparam int CW        = NumFrames > 1 ? $clog2(NumFrames) : 1;
    localparam int FlatW     = NumFrames * FrameBitsPerRow;

    typedef enum logic {IDLE, COPY} state_t;

    // Bits of frame f whose config index would be negative are never stored.
    function automatic logic [FrameBitsPerRow-1:0] frame_mask(input int f);
        logic [FrameBitsPerRow-1:0] m;
        m = '0;
        for (int b = 0; b < FrameBitsPerRow; b++)
            m[b] = (f * FrameBitsPerRow + FrameBitsPerRow - 1 - b) < NoConfigBits;
        return m;
    endfunction

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [FrameBitsPerRow-1:0] shadow_q [NumFrames];
    logic [FrameBitsPerRow-1:0] shadow_d [NumFrames];
    logic [FrameBitsPerRow-1:0] active_q [NumFrames];
    logic [FrameBitsPerRow-1:0] active_d [NumFrames];
    logic                       done_q, done_d;
    logic                       rej_q, rej_d;
    logic                       rb_valid_q, rb_valid_d;
    logic [FrameBitsPerRow-1:0] rb_data_q, rb_data_d, rb_sel;
    logic                       perr_q, perr_d;
    logic [IW-1:0]              perr_frame_q, perr_frame_d;
    logic [FlatW-1:0]           flat;
    logic                       unused_ok;

    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rej_d      = 1'b0;
        rb_valid_d = RbReq;
        rb_sel     = '0;
        for (int f = 0; f < NumFrames; f++) begin
            if (FrameStrobe[f]) shadow_d[f] = FrameData & frame_mask(f);
            if (RbFrame == IW'(f)) rb_sel = shadow_q[f];
        end
        // Readback and copy both sample shadow_q, i.e. the value before this edge's write.
        rb_data_d = RbReq ? rb_sel : rb_data_q;
        if (state_q == IDLE) begin
            if (Commit) begin
                if (perr_q) begin
                    rej_d = 1'b1;
                end else begin
                    state_d = COPY;
                    cnt_d   = '0;
                end
            end
        end else begin
            for (int f = 0; f < NumFrames; f++)
                if (cnt_q == CW'(f)) active_d[f] = shadow_q[f];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NumFrames - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

`ifdef CONFIG_MEM_PARITY_EN
    logic          par_hit, par_strobe;
    logic [IW-1:0] par_lo;

    always_comb begin
        par_strobe = 1'b0;
        par_lo     = '0;
        // Descending scan leaves the lowest strobed frame in par_lo.
        for (int f = NumFrames - 1; f >= 0; f--)
            if (FrameStrobe[f]) begin
                par_strobe = 1'b1;
                par_lo     = IW'(f);
            end
        par_hit      = par_strobe && (^{FrameData, FrameParity});
        perr_d       = par_hit | (perr_q & ~ParityClr);
        perr_frame_d = (par_hit && !perr_q) ? par_lo :
                       (ParityClr && !par_hit) ? '0 : perr_frame_q;
    end
`else
    always_comb begin
        perr_d       = 1'b0;
        perr_frame_d = '0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_q     <= '{default: '0};
            active_q     <= '{default: '0};
            done_q       <= 1'b0;
            rej_q        <= 1'b0;
            rb_valid_q   <= 1'b0;
            rb_data_q    <= '0;
            perr_q       <= 1'b0;
            perr_frame_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            done_q       <= done_d;
            rej_q        <= rej_d;
            rb_valid_q   <= rb_valid_d;
            rb_data_q    <= rb_data_d;
            perr_q       <= perr_d;
            perr_frame_q <= perr_frame_d;
        end
    end

    // Frame 0 occupies the top of the flattened vector; padding bits sit at the bottom.
    always_comb begin
        flat = '0;
        for (int f = 0; f < NumFrames; f++)
            flat[(NumFrames - 1 - f) * FrameBitsPerRow +: FrameBitsPerRow] = active_q[f];
    end

    assign ConfigBits     = flat[FlatW-1 -: NoConfigBits];
    assign ConfigBits_N   = ~ConfigBits;
    assign Busy           = state_q == COPY;
    assign CommitDone     = done_q;
    assign CommitRej      = rej_q;
    assign RbValid        = rb_valid_q;
    assign RbData         = rb_data_q;
    assign ParityErr      = perr_q;
    assign ParityErrFrame = perr_frame_q;
    assign unused_ok      = ^{FrameStrobe, flat, FrameParity, ParityClr};
endmodule

// File: tb/tb_tile_config_mem_shadow.sv
// tb_tile_config_mem_shadow: directed table-driven bench for tile_config_mem_shadow
module tb_tile_config_mem_shadow;
    logic        CLK = 1'b0;
    logic        resetn;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        FrameParity;
    logic        Commit;
    logic        ParityClr;
    logic        RbReq;
    logic [4:0]  RbFrame;
    logic        Busy, CommitDone, CommitRej, RbValid, ParityErr;
    logic [31:0] RbData;
    logic [4:0]  ParityErrFrame;
    logic [65:0] ConfigBits, ConfigBits_N;

    int checks = 0;
    int errors = 0;

    tile_config_mem_shadow dut (
        .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .FrameParity(FrameParity), .Commit(Commit), .ParityClr(ParityClr),
        .RbReq(RbReq), .RbFrame(RbFrame), .Busy(Busy), .CommitDone(CommitDone),
        .CommitRej(CommitRej), .RbValid(RbValid), .RbData(RbData),
        .ParityErr(ParityErr), .ParityErrFrame(ParityErrFrame),
        .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] d;
        logic        cm;
        logic        rq;
        logic [4:0]  rf;
        logic        busy;
        logic        done;
        logic        rbv;
        logic [31:0] rbd;
        logic [65:0] cfg;
    } vec_t;

    localparam logic [65:0] C_A = {32'hFFFFFFFF, 34'h0};
    localparam logic [65:0] C_B = {32'hFFFFFFFF, 32'h0, 2'b11};
    localparam logic [65:0] C_C = 66'h3;
    localparam logic [65:0] C_D = {32'hAAAAAAAA, 32'h0, 2'b11};
    localparam logic [65:0] C_E = {32'hAAAAAAAA, 32'hFFFFFFFF, 2'b11};

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic [19:0] st, input logic [31:0] d, input logic cm,
                        input logic rq, input logic [4:0] rf, input logic clr, input logic bad);
        FrameStrobe = st;
        FrameData   = d;
        FrameParity = (^d) ^ bad;
        Commit      = cm;
        RbReq       = rq;
        RbFrame     = rf;
        ParityClr   = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(20'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 66'(Busy), 66'd0);
        chk({tag, "_done"}, 66'(CommitDone), 66'd0);
        chk({tag, "_rej"}, 66'(CommitRej), 66'd0);
        chk({tag, "_rbv"}, 66'(RbValid), 66'd0);
        chk({tag, "_rbd"}, 66'(RbData), 66'd0);
        chk({tag, "_perr"}, 66'(ParityErr), 66'd0);
        chk({tag, "_perrf"}, 66'(ParityErrFrame), 66'd0);
        chk({tag, "_cfg"}, ConfigBits, 66'd0);
        chk({tag, "_cfgn"}, ConfigBits_N, 66'h3_FFFF_FFFF_FFFF_FFFF);
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back('{3'b001, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 66'h0});
        vt.push_back('{3'b010, 32'h00000000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 66'h0});
        vt.push_back('{3'b100, 32'hC0000000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 66'h0});
        vt.push_back('{3'b000, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 66'h0});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, C_A});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, C_A});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'hC0000000, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 32'h0, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, C_B});
        vt.push_back('{3'b001, 32'h12345678, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h12345678, C_B});
        vt.push_back('{3'b100, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'hC0000000, C_B});
        vt.push_back('{3'b001, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'hC0000000, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hC0000000, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hC0000000, C_B});
        vt.push_back('{3'b001, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hC0000000, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hC0000000, C_B});
        vt.push_back('{3'b000, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hC0000000, C_B});
        vt.push_back('{3'b001, 32'hAAAAAAAA, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hC0000000, C_C});
        vt.push_back('{3'b000, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hC0000000, C_C});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hC0000000, C_C});
        vt.push_back('{3'b110, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, C_C});
        vt.push_back('{3'b000, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hAAAAAAAA, C_C});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hAAAAAAAA, C_D});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hAAAAAAAA, C_E});
        vt.push_back('{3'b000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAAAAAAAA, C_E});

        resetn = 1'b0;
        idle();
        chk_reset_state("reset");
        resetn = 1'b1;

        foreach (vt[i]) begin
            step({17'h0, vt[i].st}, vt[i].d, vt[i].cm, vt[i].rq, vt[i].rf, 1'b0, 1'b0);
            chk($sformatf("v%0d_busy", i), 66'(Busy), 66'(vt[i].busy));
            chk($sformatf("v%0d_done", i), 66'(CommitDone), 66'(vt[i].done));
            chk($sformatf("v%0d_rbv", i), 66'(RbValid), 66'(vt[i].rbv));
            chk($sformatf("v%0d_rbd", i), 66'(RbData), 66'(vt[i].rbd));
            chk($sformatf("v%0d_cfg", i), ConfigBits, vt[i].cfg);
            chk($sformatf("v%0d_cfgn", i), ConfigBits_N, ~vt[i].cfg);
            chk($sformatf("v%0d_rej", i), 66'(CommitRej), 66'd0);
            chk($sformatf("v%0d_perr", i), 66'(ParityErr), 66'd0);
        end

        // Reset in the middle of a copy: no CommitDone, everything back to reset values.
        step(20'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("mid_busy0", 66'(Busy), 66'd1);
        idle();
        chk("mid_busy1", 66'(Busy), 66'd1);
        resetn = 1'b0;
        idle();
        chk_reset_state("midrst");
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("midrst_nodone%0d", i), 66'(CommitDone), 66'd0);
            chk($sformatf("midrst_cfg%0d", i), ConfigBits, 66'd0);
        end
        step(20'h0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("midrst_shadow0", 66'(RbData), 66'd0);
        chk("midrst_rbv", 66'(RbValid), 66'd1);

`ifdef CONFIG_MEM_PARITY_EN
        step(20'h2, 32'h1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("par_err", 66'(ParityErr), 66'd1);
        chk("par_frame", 66'(ParityErrFrame), 66'd1);
        step(20'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("par_rej", 66'(CommitRej), 66'd1);
        chk("par_rej_busy", 66'(Busy), 66'd0);
        idle();
        chk("par_rej_pulse", 66'(CommitRej), 66'd0);
        chk("par_rej_busy2", 66'(Busy), 66'd0);
        step(20'h5, 32'h1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("par_win_err", 66'(ParityErr), 66'd1);
        chk("par_win_frame", 66'(ParityErrFrame), 66'd1);
        step(20'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("par_clr", 66'(ParityErr), 66'd0);
        chk("par_clr_frame", 66'(ParityErrFrame), 66'd0);
        step(20'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("par_commit_busy", 66'(Busy), 66'd1);
        chk("par_commit_norej", 66'(CommitRej), 66'd0);
        idle();
        idle();
        chk("par_copy_busy", 66'(Busy), 66'd1);
        idle();
        chk("par_copy_done", 66'(CommitDone), 66'd1);
        chk("par_copy_cfg", ConfigBits, {32'h1, 32'h1, 2'b00});
`else
        step(20'h2, 32'h1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("nopar_err", 66'(ParityErr), 66'd0);
        step(20'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("nopar_rej", 66'(CommitRej), 66'd0);
        chk("nopar_busy", 66'(Busy), 66'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
